// File: rtl/axi_arbiter.sv
// Round-robin arbiter sharing one AXI4 master port between instruction fetch (ID 0) and load/store (ID 1).
// Single outstanding single-beat transaction; one-cycle grant latency; registered one-cycle response pulse.
module axi_arbiter #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic [2:0]          if_size,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req_valid,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [2:0]          ls_size,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_wstrb,
  output logic                ls_resp_valid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic [ID_W-1:0]     axi_ar_id,
  output logic [ADDR_W-1:0]   axi_ar_addr,
  output logic [2:0]          axi_ar_size,
  output logic [7:0]          axi_ar_len,
  output logic [1:0]          axi_ar_burst,
  output logic                axi_ar_valid,
  input  logic                axi_ar_ready,
  input  logic [ID_W-1:0]     axi_r_id,
  input  logic [DATA_W-1:0]   axi_r_data,
  input  logic [1:0]          axi_r_resp,
  input  logic                axi_r_last,
  input  logic                axi_r_valid,
  output logic                axi_r_ready,
  output logic [ID_W-1:0]     axi_aw_id,
  output logic [ADDR_W-1:0]   axi_aw_addr,
  output logic [2:0]          axi_aw_size,
  output logic [7:0]          axi_aw_len,
  output logic [1:0]          axi_aw_burst,
  output logic                axi_aw_valid,
  input  logic                axi_aw_ready,
  output logic [DATA_W-1:0]   axi_w_data,
  output logic [DATA_W/8-1:0] axi_w_strb,
  output logic                axi_w_last,
  output logic                axi_w_valid,
  input  logic                axi_w_ready,
  input  logic [ID_W-1:0]     axi_b_id,
  input  logic [1:0]          axi_b_resp,
  input  logic                axi_b_valid,
  output logic                axi_b_ready
);

  typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

  state_t              state, state_nxt;
  logic                owner;       // 0 = IF, 1 = LS
  logic                last_grant;
  logic                aw_done, w_done;
  logic [ADDR_W-1:0]   req_addr;
  logic [2:0]          req_size;
  logic [DATA_W-1:0]   req_wdata;
  logic [DATA_W/8-1:0] req_wstrb;

  logic if_elig, ls_elig, grant_vld, grant_ls, grant_we;
  logic ar_hs, r_hs, aw_hs, w_hs, b_hs, wr_both_done;
  logic unused_ok;

  // A requester still holds valid during its own response pulse; mask it so it is not re-granted.
  assign if_elig   = if_req_valid & ~if_resp_valid;
  assign ls_elig   = ls_req_valid & ~ls_resp_valid;
  assign grant_vld = (state == IDLE) & (if_elig | ls_elig);
  assign grant_ls  = ls_elig & (~if_elig | ~last_grant);
  assign grant_we  = grant_ls & ls_we;

  assign ar_hs        = axi_ar_valid & axi_ar_ready;
  assign r_hs         = axi_r_valid & axi_r_ready;
  assign aw_hs        = axi_aw_valid & axi_aw_ready;
  assign w_hs         = axi_w_valid & axi_w_ready;
  assign b_hs         = axi_b_valid & axi_b_ready;
  assign wr_both_done = (aw_done | aw_hs) & (w_done | w_hs);

  assign unused_ok = ^{axi_r_resp, axi_b_resp, axi_r_id, axi_b_id, axi_r_last};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_vld) state_nxt = grant_we ? WR_REQ : RD_ADDR;
      RD_ADDR: if (ar_hs) state_nxt = RD_DATA;
      RD_DATA: if (r_hs) state_nxt = IDLE;
      WR_REQ:  if (wr_both_done) state_nxt = WR_RESP;
      WR_RESP: if (b_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    axi_ar_valid = 1'b0;
    axi_r_ready  = 1'b0;
    axi_aw_valid = 1'b0;
    axi_w_valid  = 1'b0;
    axi_b_ready  = 1'b0;
    case (state)
      RD_ADDR: axi_ar_valid = 1'b1;
      RD_DATA: axi_r_ready  = 1'b1;
      WR_REQ: begin
        axi_aw_valid = ~aw_done;
        axi_w_valid  = ~w_done;
      end
      WR_RESP: axi_b_ready = 1'b1;
      default: ;
    endcase
  end

  assign axi_ar_id    = {{(ID_W-1){1'b0}}, owner};
  assign axi_ar_addr  = req_addr;
  assign axi_ar_size  = req_size;
  assign axi_ar_len   = 8'd0;
  assign axi_ar_burst = 2'b01;
  assign axi_aw_id    = {{(ID_W-1){1'b0}}, owner};
  assign axi_aw_addr  = req_addr;
  assign axi_aw_size  = req_size;
  assign axi_aw_len   = 8'd0;
  assign axi_aw_burst = 2'b01;
  assign axi_w_data   = req_wdata;
  assign axi_w_strb   = req_wstrb;
  assign axi_w_last   = axi_w_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      owner         <= 1'b0;
      last_grant    <= 1'b1;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      req_addr      <= '0;
      req_size      <= '0;
      req_wdata     <= '0;
      req_wstrb     <= '0;
      if_resp_valid <= 1'b0;
      ls_resp_valid <= 1'b0;
      if_rdata      <= '0;
      ls_rdata      <= '0;
    end else begin
      if (grant_vld) begin
        owner      <= grant_ls;
        last_grant <= grant_ls;
        req_addr   <= grant_ls ? ls_addr : if_addr;
        req_size   <= grant_ls ? ls_size : if_size;
        req_wdata  <= ls_wdata;
        req_wstrb  <= ls_wstrb;
      end
      if (state == WR_REQ) begin
        aw_done <= wr_both_done ? 1'b0 : (aw_done | aw_hs);
        w_done  <= wr_both_done ? 1'b0 : (w_done | w_hs);
      end
      if_resp_valid <= r_hs & ~owner;
      ls_resp_valid <= (r_hs & owner) | b_hs;
      if (r_hs & ~owner) if_rdata <= axi_r_data;
      if (r_hs & owner)  ls_rdata <= axi_r_data;
    end
  end

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed bench for axi_arbiter: tasks drive the pipeline side and a simple AXI slave, checking hand-computed results.
module tb_axi_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_valid;
  logic [63:0] if_addr;
  logic [2:0]  if_size;
  logic        if_resp_valid;
  logic [63:0] if_rdata;
  logic        ls_req_valid, ls_we;
  logic [63:0] ls_addr;
  logic [2:0]  ls_size;
  logic [63:0] ls_wdata;
  logic [7:0]  ls_wstrb;
  logic        ls_resp_valid;
  logic [63:0] ls_rdata;
  logic [3:0]  axi_ar_id, axi_r_id, axi_aw_id, axi_b_id;
  logic [63:0] axi_ar_addr, axi_aw_addr, axi_r_data, axi_w_data;
  logic [2:0]  axi_ar_size, axi_aw_size;
  logic [7:0]  axi_ar_len, axi_aw_len, axi_w_strb;
  logic [1:0]  axi_ar_burst, axi_aw_burst, axi_r_resp, axi_b_resp;
  logic        axi_ar_valid, axi_ar_ready, axi_r_last, axi_r_valid, axi_r_ready;
  logic        axi_aw_valid, axi_aw_ready, axi_w_last, axi_w_valid, axi_w_ready;
  logic        axi_b_valid, axi_b_ready;

  int vec = 0;
  int err = 0;

  axi_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req_valid(if_req_valid), .if_addr(if_addr), .if_size(if_size),
    .if_resp_valid(if_resp_valid), .if_rdata(if_rdata),
    .ls_req_valid(ls_req_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_size(ls_size),
    .ls_wdata(ls_wdata), .ls_wstrb(ls_wstrb), .ls_resp_valid(ls_resp_valid), .ls_rdata(ls_rdata),
    .axi_ar_id(axi_ar_id), .axi_ar_addr(axi_ar_addr), .axi_ar_size(axi_ar_size),
    .axi_ar_len(axi_ar_len), .axi_ar_burst(axi_ar_burst), .axi_ar_valid(axi_ar_valid),
    .axi_ar_ready(axi_ar_ready),
    .axi_r_id(axi_r_id), .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last),
    .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready),
    .axi_aw_id(axi_aw_id), .axi_aw_addr(axi_aw_addr), .axi_aw_size(axi_aw_size),
    .axi_aw_len(axi_aw_len), .axi_aw_burst(axi_aw_burst), .axi_aw_valid(axi_aw_valid),
    .axi_aw_ready(axi_aw_ready),
    .axi_w_data(axi_w_data), .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready),
    .axi_b_id(axi_b_id), .axi_b_resp(axi_b_resp), .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Slave side of one read: wait for ar, accept it, give r after r_delay idle cycles.
  // Returns one step after the r handshake edge, i.e. in the response-pulse cycle.
  task automatic rd_slave(input logic [63:0] data, input int r_delay,
                          output logic [3:0] id_seen, output logic [63:0] addr_seen, output bit ok);
    ok = 1'b0;
    id_seen = 'x;
    addr_seen = 'x;
    for (int i = 0; i < 20 && !axi_ar_valid; i++) tick();
    if (!axi_ar_valid) return;
    id_seen = axi_ar_id;
    addr_seen = axi_ar_addr;
    axi_ar_ready = 1'b1;
    tick();
    axi_ar_ready = 1'b0;
    for (int d = 0; d < r_delay; d++) tick();
    axi_r_valid = 1'b1;
    axi_r_data = data;
    tick();
    axi_r_valid = 1'b0;
    ok = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    vec++;
    if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_resp_valid, ls_resp_valid} !== 7'b0) begin
      err++;
      $display("FAIL reset_handshakes got=%b want=0", {axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_resp_valid, ls_resp_valid});
    end
    vec++;
    if (if_rdata !== 64'h0 || ls_rdata !== 64'h0) begin
      err++;
      $display("FAIL reset_rdata got if=%h ls=%h want 0", if_rdata, ls_rdata);
    end
  endtask

  task automatic test_if_read;
    logic [3:0] id;
    logic [63:0] a;
    bit ok;
    if_req_valid = 1'b1;
    if_addr = 64'h8000_0000;
    if_size = 3'b011;
    vec++;
    if (axi_ar_valid !== 1'b0) begin err++; $display("FAIL if_grant_cycle_ar got=%b want=0", axi_ar_valid); end
    tick();
    vec++;
    if ({axi_ar_size, axi_ar_len, axi_ar_burst} !== {3'b011, 8'd0, 2'b01}) begin
      err++;
      $display("FAIL if_ar_fields got size=%b len=%h burst=%b want 011/00/01", axi_ar_size, axi_ar_len, axi_ar_burst);
    end
    rd_slave(64'h1122_3344_5566_7788, 0, id, a, ok);
    vec++;
    if (!ok) begin err++; $display("FAIL if_read_timeout got no ar_valid want ar_valid"); end
    vec++;
    if (id !== 4'd0 || a !== 64'h8000_0000) begin err++; $display("FAIL if_ar got id=%0d addr=%h want 0/80000000", id, a); end
    vec++;
    if (if_resp_valid !== 1'b1 || ls_resp_valid !== 1'b0) begin
      err++;
      $display("FAIL if_resp_pulse got if=%b ls=%b want 1/0", if_resp_valid, ls_resp_valid);
    end
    vec++;
    if (if_rdata !== 64'h1122_3344_5566_7788) begin err++; $display("FAIL if_rdata got=%h want=1122334455667788", if_rdata); end
    if_req_valid = 1'b0;
    tick();
    vec++;
    if (if_resp_valid !== 1'b0 || axi_ar_valid !== 1'b0) begin
      err++;
      $display("FAIL if_resp_one_cycle got resp=%b ar=%b want 0/0", if_resp_valid, axi_ar_valid);
    end
    vec++;
    if (if_rdata !== 64'h1122_3344_5566_7788) begin err++; $display("FAIL if_rdata_hold got=%h want=1122334455667788", if_rdata); end
  endtask

  task automatic test_tie;
    logic [3:0] id;
    logic [63:0] a;
    bit ok;
    do_reset();
    if_req_valid = 1'b1; if_addr = 64'h100;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 64'h200; ls_size = 3'b010;
    vec++;
    if (axi_ar_valid !== 1'b0) begin err++; $display("FAIL tie_grant1_ar got=%b want=0", axi_ar_valid); end
    rd_slave(64'hAAAA_0000_0000_0001, 0, id, a, ok);
    vec++;
    if (!ok || id !== 4'd0 || a !== 64'h100) begin err++; $display("FAIL tie_first got ok=%b id=%0d addr=%h want 1/0/100", ok, id, a); end
    vec++;
    if (if_resp_valid !== 1'b1 || ls_resp_valid !== 1'b0) begin
      err++;
      $display("FAIL tie_first_resp got if=%b ls=%b want 1/0", if_resp_valid, ls_resp_valid);
    end
    vec++;
    if (axi_ar_valid !== 1'b0) begin err++; $display("FAIL tie_grant2_ar got=%b want=0", axi_ar_valid); end
    if_req_valid = 1'b0;
    rd_slave(64'hBBBB_0000_0000_0002, 0, id, a, ok);
    vec++;
    if (!ok || id !== 4'd1 || a !== 64'h200) begin err++; $display("FAIL tie_second got ok=%b id=%0d addr=%h want 1/1/200", ok, id, a); end
    vec++;
    if (ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || ls_rdata !== 64'hBBBB_0000_0000_0002) begin
      err++;
      $display("FAIL tie_second_resp got ls=%b if=%b rdata=%h want 1/0/bbbb000000000002", ls_resp_valid, if_resp_valid, ls_rdata);
    end
    ls_req_valid = 1'b0;
    tick();
  endtask

  task automatic test_write;
    ls_req_valid = 1'b1; ls_we = 1'b1; ls_addr = 64'h8000_0010; ls_size = 3'b010;
    ls_wdata = 64'hDEAD_BEEF; ls_wstrb = 8'h0F;
    axi_aw_ready = 1'b0; axi_w_ready = 1'b1;
    vec++;
    if (axi_aw_valid !== 1'b0 || axi_w_valid !== 1'b0) begin
      err++;
      $display("FAIL wr_grant_cycle got aw=%b w=%b want 0/0", axi_aw_valid, axi_w_valid);
    end
    tick();
    vec++;
    if ({axi_aw_valid, axi_w_valid, axi_w_last} !== 3'b111 || axi_aw_id !== 4'd1 || axi_aw_addr !== 64'h8000_0010) begin
      err++;
      $display("FAIL wr_entry got aw=%b w=%b last=%b id=%0d addr=%h want 1/1/1/1/80000010", axi_aw_valid, axi_w_valid, axi_w_last, axi_aw_id, axi_aw_addr);
    end
    vec++;
    if (axi_w_data !== 64'hDEAD_BEEF || axi_w_strb !== 8'h0F || axi_aw_len !== 8'd0 || axi_aw_burst !== 2'b01) begin
      err++;
      $display("FAIL wr_payload got data=%h strb=%h len=%h burst=%b want deadbeef/0f/00/01", axi_w_data, axi_w_strb, axi_aw_len, axi_aw_burst);
    end
    tick();
    axi_w_ready = 1'b0;
    vec++;
    if (axi_w_valid !== 1'b0 || axi_w_last !== 1'b0 || axi_aw_valid !== 1'b1) begin
      err++;
      $display("FAIL wr_cycle1 got w=%b last=%b aw=%b want 0/0/1", axi_w_valid, axi_w_last, axi_aw_valid);
    end
    tick();
    vec++;
    if (axi_aw_valid !== 1'b1 || axi_b_ready !== 1'b0) begin
      err++;
      $display("FAIL wr_cycle2 got aw=%b b_ready=%b want 1/0", axi_aw_valid, axi_b_ready);
    end
    axi_aw_ready = 1'b1;
    tick();
    axi_aw_ready = 1'b0;
    vec++;
    if (axi_aw_valid !== 1'b0 || axi_w_valid !== 1'b0 || axi_b_ready !== 1'b1) begin
      err++;
      $display("FAIL wr_cycle3 got aw=%b w=%b b_ready=%b want 0/0/1", axi_aw_valid, axi_w_valid, axi_b_ready);
    end
    vec++;
    if (ls_resp_valid !== 1'b0) begin err++; $display("FAIL wr_early_resp got=%b want=0", ls_resp_valid); end
    axi_b_valid = 1'b1;
    tick();
    axi_b_valid = 1'b0;
    vec++;
    if (ls_resp_valid !== 1'b1 || axi_b_ready !== 1'b0 || ls_rdata !== 64'hBBBB_0000_0000_0002) begin
      err++;
      $display("FAIL wr_resp got resp=%b b_ready=%b rdata=%h want 1/0/bbbb000000000002", ls_resp_valid, axi_b_ready, ls_rdata);
    end
    ls_req_valid = 1'b0;
    ls_we = 1'b0;
    tick();
    vec++;
    if (ls_resp_valid !== 1'b0 || axi_aw_valid !== 1'b0) begin
      err++;
      $display("FAIL wr_after got resp=%b aw=%b want 0/0", ls_resp_valid, axi_aw_valid);
    end
  endtask

  task automatic test_alternate;
    logic [3:0] id;
    logic [63:0] a;
    logic [63:0] d;
    bit ok;
    do_reset();
    if_req_valid = 1'b1; if_addr = 64'h1000;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 64'h2000;
    for (int i = 0; i < 6; i++) begin
      d = 64'hC0DE_0000_0000_0000 + 64'(i);
      rd_slave(d, 1, id, a, ok);
      if (i == 5) begin
        if_req_valid = 1'b0;
        ls_req_valid = 1'b0;
      end
      vec++;
      if (!ok || id !== 4'(i % 2)) begin err++; $display("FAIL alt_grant%0d got ok=%b id=%0d want 1/%0d", i, ok, id, i % 2); end
      vec++;
      if ((i % 2 == 0 && (if_resp_valid !== 1'b1 || ls_resp_valid !== 1'b0 || if_rdata !== d)) ||
          (i % 2 == 1 && (ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || ls_rdata !== d))) begin
        err++;
        $display("FAIL alt_resp%0d got if=%b ls=%b ifd=%h lsd=%h want owner %0d data %h", i, if_resp_valid, ls_resp_valid, if_rdata, ls_rdata, i % 2, d);
      end
    end
    tick();
    vec++;
    if (axi_ar_valid !== 1'b0 || if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin
      err++;
      $display("FAIL alt_quiet got ar=%b if=%b ls=%b want 0/0/0", axi_ar_valid, if_resp_valid, ls_resp_valid);
    end
  endtask

  task automatic test_reset_mid;
    if_req_valid = 1'b1; if_addr = 64'h3000;
    tick();
    axi_ar_ready = 1'b1;
    tick();
    axi_ar_ready = 1'b0;
    vec++;
    if (axi_r_ready !== 1'b1) begin err++; $display("FAIL mid_in_rd_data got r_ready=%b want 1", axi_r_ready); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    if_req_valid = 1'b0;
    vec++;
    if ({axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_resp_valid, ls_resp_valid} !== 7'b0) begin
      err++;
      $display("FAIL mid_reset got=%b want=0", {axi_ar_valid, axi_r_ready, axi_aw_valid, axi_w_valid, axi_b_ready, if_resp_valid, ls_resp_valid});
    end
    tick();
    vec++;
    if (if_resp_valid !== 1'b0 || axi_ar_valid !== 1'b0 || if_rdata !== 64'h0) begin
      err++;
      $display("FAIL mid_after got resp=%b ar=%b rdata=%h want 0/0/0", if_resp_valid, axi_ar_valid, if_rdata);
    end
  endtask

  task automatic test_ls_delay;
    ls_req_valid = 1'b1; ls_we = 1'b0; ls_addr = 64'h4000; ls_size = 3'b011;
    tick();
    vec++;
    if (axi_ar_valid !== 1'b1 || axi_ar_id !== 4'd1 || axi_ar_addr !== 64'h4000) begin
      err++;
      $display("FAIL lsd_ar got valid=%b id=%0d addr=%h want 1/1/4000", axi_ar_valid, axi_ar_id, axi_ar_addr);
    end
    axi_ar_ready = 1'b1;
    tick();
    axi_ar_ready = 1'b0;
    axi_r_data = 64'hFFFF_EEEE_DDDD_CCCC;
    for (int i = 0; i < 5; i++) begin
      vec++;
      if (axi_r_ready !== 1'b1 || ls_resp_valid !== 1'b0 || ls_rdata !== 64'h0) begin
        err++;
        $display("FAIL lsd_wait%0d got r_ready=%b resp=%b rdata=%h want 1/0/0", i, axi_r_ready, ls_resp_valid, ls_rdata);
      end
      tick();
    end
    axi_r_valid = 1'b1;
    tick();
    axi_r_valid = 1'b0;
    vec++;
    if (ls_resp_valid !== 1'b1 || ls_rdata !== 64'hFFFF_EEEE_DDDD_CCCC || axi_r_ready !== 1'b0) begin
      err++;
      $display("FAIL lsd_resp got resp=%b rdata=%h r_ready=%b want 1/ffffeeeeddddcccc/0", ls_resp_valid, ls_rdata, axi_r_ready);
    end
    ls_req_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1;
    if_req_valid = 1'b0; if_addr = '0; if_size = 3'b011;
    ls_req_valid = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_size = 3'b011; ls_wdata = '0; ls_wstrb = '0;
    axi_ar_ready = 1'b0; axi_r_id = '0; axi_r_data = '0; axi_r_resp = '0; axi_r_last = 1'b1; axi_r_valid = 1'b0;
    axi_aw_ready = 1'b0; axi_w_ready = 1'b0; axi_b_id = '0; axi_b_resp = '0; axi_b_valid = 1'b0;
    test_reset();
    test_if_read();
    test_tie();
    test_write();
    test_alternate();
    test_reset_mid();
    test_ls_delay();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end
endmodule

// File: doc/axi_arbiter.md
Name: axi_arbiter

Overview:
- Shares the single AXI4 master port between the instruction-fetch requester (IF, read-only) and the load/store requester (LS, read/write).
- Only one transaction is outstanding at a time. Every transaction is a single beat.
- Sits between the pipeline's fetch/LSU stages and the AXI memory slave.
- Uses round-robin arbitration and returns a registered, one-cycle response pulse to the granted requester.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, data width (strobe width is DATA_W/8)
- ID_W, 4, AXI ID width; IF transactions use ID 0, LS transactions use ID 1

Ports:
- clk  input  1  clock; one clock domain
- rst  input  1  reset; synchronous, active-high
- if_req_valid  input  1  fetch request; held until if_resp_valid
- if_addr / if_size  input  ADDR_W / 3  fetch address / AXI size encoding
- if_resp_valid  output  1  one-cycle pulse: fetch complete
- if_rdata  output  DATA_W  fetch data; valid while if_resp_valid=1
- ls_req_valid  input  1  LS request; held until ls_resp_valid
- ls_we  input  1  1 = write, 0 = read
- ls_addr / ls_size  input  ADDR_W / 3  LS address / AXI size encoding
- ls_wdata / ls_wstrb  input  DATA_W / DATA_W/8  write data / byte strobes
- ls_resp_valid  output  1  one-cycle pulse: LS complete
- ls_rdata  output  DATA_W  load data; valid while ls_resp_valid=1
- axi_ar_id / axi_ar_addr / axi_ar_size  output  ID_W / ADDR_W / 3  read address
- axi_ar_len / axi_ar_burst  output  8 / 2  constant 0 / 2'b01
- axi_ar_valid  output  1; axi_ar_ready  input  1
- axi_r_id / axi_r_data / axi_r_resp  input  ID_W / DATA_W / 2; axi_r_last  input  1
- axi_r_valid  input  1; axi_r_ready  output  1
- axi_aw_id / axi_aw_addr / axi_aw_size  output  ID_W / ADDR_W / 3
- axi_aw_len / axi_aw_burst  output  8 / 2  constant 0 / 2'b01
- axi_aw_valid  output  1; axi_aw_ready  input  1
- axi_w_data / axi_w_strb  output  DATA_W / DATA_W/8
- axi_w_last  output  1  equals axi_w_valid
- axi_w_valid  output  1; axi_w_ready  input  1
- axi_b_id / axi_b_resp  input  ID_W / 2
- axi_b_valid  input  1; axi_b_ready  output  1

Behaviour:
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP. A register owner (0=IF, 1=LS) and a register last_grant record who holds the bus.
- Reset (rst=1 at posedge): state=IDLE, last_grant=LS (so IF wins the first tie).
  - All valid/ready outputs are 0. if_rdata, ls_rdata and the latched request registers are 0.
  - Reset mid-transaction abandons the transaction with no response pulse; the slave is not drained.
- IDLE:
  - Grant when exactly one requester is valid; if both are valid, grant the requester that is not last_grant.
  - On grant, latch addr, size, we, wdata and wstrb, and set owner and last_grant.
  - Next state: RD_ADDR for IF or LS read; WR_REQ for LS write.
  - No AXI valid is asserted in the grant cycle (one-cycle grant latency).
- RD_ADDR: axi_ar_valid=1 with the latched addr/size and id=owner. On ar handshake, go to RD_DATA.
- RD_DATA: axi_r_ready=1. On r handshake:
  - register axi_r_data into the owner's rdata;
  - pulse the owner's resp_valid in the next cycle, entering IDLE in that same cycle.
- WR_REQ:
  - axi_aw_valid and axi_w_valid both rise on entry.
  - Each stays high until its own handshake, tracked by aw_done/w_done flags; both signals must be presented together.
  - When both handshakes are done (same cycle or different cycles), go to WR_RESP and clear the flags.
- WR_RESP: axi_b_ready=1. On b handshake, pulse ls_resp_valid next cycle and return to IDLE. ls_rdata is unchanged.
- A new grant may be made in the cycle resp_valid pulses (back-to-back service); the requester that just completed is not re-granted while the other is waiting.
- Requests must stay stable while valid and before grant. Changes after grant are ignored.
- axi_r_resp, axi_b_resp, axi_r_id, axi_b_id and axi_r_last are not checked.
- rdata registers hold their value between responses.

Test Plan:
- Reset, then IF-only read addr 0x8000_0000, size 3'b011, slave returns 0x1122_3344_5566_7788 -> ar_id=0; if_resp_valid pulses exactly one cycle after the r handshake; if_rdata=0x1122334455667788.
- IF and LS read requested in the same cycle after reset -> IF granted first (ar_id=0), then LS (ar_id=1); two resp pulses in that order; no AXI valid in either grant cycle.
- LS write addr 0x8000_0010, wdata 0xDEAD_BEEF, wstrb 0x0F; slave delays aw_ready by 2 cycles and w_ready by 0 -> w_valid drops after 1 cycle, aw_valid after 3; ls_resp_valid one cycle after the b handshake.
- Both requesters held valid continuously for 6 transactions -> grants alternate IF, LS, IF, LS, IF, LS.
- Assert rst during RD_DATA with r_valid=0 -> next cycle all AXI valids/readies are 0, state is IDLE, no resp pulse.
- LS read with r_valid delayed 5 cycles -> r_ready held high throughout; ls_rdata updates only on the handshake.
